// File: rtl/fetch_line_buffer.sv
// Instruction-fetch front end: one 64-byte line buffer refilled over AXI read bursts,
// presenting one 32-bit instruction per cycle with its PC to decode.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no fetch PC yet; waits for the first redirect
// REQ    | AR issued for the missing line; address frozen until handshake
// FILL   | accepting read beats into the line buffer until rlast
// SERVE  | present the instruction at pc on a hit; a miss goes to REQ
module fetch_line_buffer #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BEATS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int BEAT_OFF = $clog2(DATA_WIDTH / 8);
    localparam int LINE_OFF = $clog2((DATA_WIDTH / 8) * LINE_BEATS);
    localparam int IDX_W    = LINE_OFF - BEAT_OFF;
    localparam int CNT_W    = IDX_W + 1;
    localparam int TAG_W    = ADDR_WIDTH - LINE_OFF;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_BEATS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_SERVE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic                    line_valid_q, line_valid_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0]   line_q [LINE_BEATS];
    logic                    line_we;

    logic                    hit;
    logic [ADDR_WIDTH-1:0]   redirect_pc_w;
    logic [ADDR_WIDTH-1:0]   line_addr;
    logic [DATA_WIDTH-1:0]   beat_w;
    logic [BEAT_OFF-3:0]     word_sel;
    logic [31:0]             word_w;

    assign redirect_pc_w = redirect_pc & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    assign line_addr     = {pc_q[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
    assign hit           = line_valid_q && (tag_q == pc_q[ADDR_WIDTH-1:LINE_OFF]);

    assign beat_w   = line_q[pc_q[LINE_OFF-1:BEAT_OFF]];
    assign word_sel = pc_q[BEAT_OFF-1:2];
    assign word_w   = beat_w[{word_sel, 5'b00000} +: 32];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        araddr_d     = araddr_q;
        tag_d        = tag_q;
        line_valid_d = line_valid_q;
        beat_cnt_d   = beat_cnt_q;
        line_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc_w;
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_w;
                end else if (hit) begin
                    if (instr_ready) pc_d = pc_q + ADDR_WIDTH'(4);
                end else begin
                    araddr_d = line_addr;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_valid) pc_d = redirect_pc_w;
                if (m_axi_arready) begin
                    tag_d        = araddr_q[ADDR_WIDTH-1:LINE_OFF];
                    line_valid_d = 1'b0;
                    beat_cnt_d   = '0;
                    state_d      = S_FILL;
                end
            end
            S_FILL: begin
                if (redirect_valid) pc_d = redirect_pc_w;
                if (m_axi_rvalid) begin
                    // Overlong bursts: extra beats are dropped, rlast still ends the fill.
                    if (beat_cnt_q != CNT_FULL) begin
                        line_we    = 1'b1;
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    if (m_axi_rlast) begin
                        line_valid_d = 1'b1;
                        state_d      = S_SERVE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            araddr_q     <= '0;
            tag_q        <= '0;
            line_valid_q <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            araddr_q     <= araddr_d;
            tag_q        <= tag_d;
            line_valid_q <= line_valid_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) line_q[beat_cnt_q[IDX_W-1:0]] <= m_axi_rdata;
    end

    assign instr_valid   = (state_q == S_SERVE) && hit;
    assign instr         = instr_valid ? word_w : 32'd0;
    assign instr_pc      = pc_q;

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(LINE_BEATS - 1);
    assign m_axi_arsize  = 3'(BEAT_OFF);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == S_REQ);
    assign m_axi_rready  = (state_q == S_FILL);

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Self-checking bench for fetch_line_buffer: AXI read slave backed by an address-hashed
// memory, a PC-stream reference model, directed scenarios and a randomized run.
`timescale 1ns/1ps
module tb_fetch_line_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [12:0] m_axi_arid;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    always #5 clk = ~clk;

    fetch_line_buffer dut (
        .clk           (clk),
        .reset         (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;
    int          n_acc = 0;
    logic [63:0] model_pc = 64'd0;

    bit          ar_pend = 1'b0;
    logic [63:0] ar_line = 64'd0;
    int          beat_idx = 0;
    int          ar_wait = 0;
    int          ar_delay_knob = 0;
    bit          r_rand = 1'b0;
    bit          r_acc = 1'b0;
    bit          prev_arvalid = 1'b0;
    bit          prev_arready = 1'b0;
    logic [63:0] prev_araddr = 64'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents: every 32-bit word is a hash of its own byte address.
    function automatic logic [31:0] instr_at(input logic [63:0] a);
        return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a);
        return {instr_at(a + 64'd4), instr_at(a)};
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Observe at negedge: values seen here are what the next posedge will act on.
    always @(negedge clk) begin
        if (rst) begin
            model_pc     = 64'd0;
            ar_pend      = 1'b0;
            beat_idx     = 0;
            ar_wait      = 0;
            r_acc        = 1'b0;
            prev_arvalid = 1'b0;
            prev_arready = 1'b0;
        end else begin
            if (prev_arvalid && !prev_arready) begin
                check_eq("arvalid_hold", 64'(m_axi_arvalid), 64'd1);
                check_eq("araddr_hold", m_axi_araddr, prev_araddr);
            end else if (m_axi_arvalid) begin
                check_eq("araddr_line", m_axi_araddr, model_pc & ~64'h3F);
            end
            if (m_axi_arvalid) begin
                check_eq("ar_fixed", 64'({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst}),
                         64'({13'd0, 8'd7, 3'd3, 2'b01}));
                check_eq("ar_single", 64'(ar_pend), 64'd0);
            end
            if (m_axi_rready) check_eq("r_outstanding", 64'(ar_pend), 64'd1);
            if (instr_valid) begin
                check_eq("instr_pc", instr_pc, model_pc);
                check_eq("instr", 64'(instr), 64'(instr_at(model_pc)));
            end

            if (redirect_valid) model_pc = redirect_pc & ~64'h3;
            else if (instr_valid && instr_ready) begin
                model_pc = model_pc + 64'd4;
                n_acc++;
            end

            r_acc = m_axi_rvalid && m_axi_rready;
            if (r_acc) begin
                if (m_axi_rlast) begin
                    ar_pend  = 1'b0;
                    beat_idx = 0;
                end else beat_idx++;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_pend = 1'b1;
                ar_line = m_axi_araddr;
                ar_wait = 0;
            end else if (m_axi_arvalid) ar_wait++;
            prev_arvalid = m_axi_arvalid;
            prev_arready = m_axi_arready;
            prev_araddr  = m_axi_araddr;
        end
    end

    // AXI read slave outputs, driven just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_axi_rdata   = 64'd0;
        end else begin
            m_axi_arready = (ar_delay_knob < 0) ? ($urandom_range(0, 2) == 0)
                                                : (ar_wait >= ar_delay_knob);
            if (!(m_axi_rvalid && !r_acc)) begin
                if (ar_pend) begin
                    m_axi_rvalid = r_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                    m_axi_rdata  = beat_data(ar_line + 64'(8 * beat_idx));
                    m_axi_rlast  = (beat_idx == 7);
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid_pc(input logic [63:0] pc, input int budget, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == pc) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq(tag, 64'(found), 64'd1);
    endtask

    task automatic wait_ar(input logic [63:0] addr, input int budget, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_axi_arvalid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq({tag, "_seen"}, 64'(found), 64'd1);
        check_eq({tag, "_addr"}, m_axi_araddr, addr);
    endtask

    function automatic logic [63:0] pick_pc();
        logic [63:0] base;
        case ($urandom_range(0, 3))
            0: base = 64'h0000_0000_8000_0000;
            1: base = 64'h0000_0000_9000_0000;
            2: base = 64'hFFFF_FFFF_FFFF_FF80;
            default: base = {$urandom, $urandom};
        endcase
        return base + 64'($urandom_range(0, 63) * 4) + 64'($urandom_range(0, 3));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_redir, t_ar, t_last, t_val, nvalid, n_low, nb, acc0;
        logic [31:0] held_instr;

        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        instr_ready = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        m_axi_rdata = 64'd0;
        #1 rst = 1'b1;
        #2;
        check_eq("rst_ctrl", 64'({instr_valid, m_axi_arvalid, m_axi_rready}), 64'd0);
        check_eq("rst_araddr", m_axi_araddr, 64'd0);
        check_eq("rst_instr", 64'(instr), 64'd0);
        check_eq("rst_pc", instr_pc, 64'd0);
        check_eq("rst_arfix", 64'({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst}),
                 64'({13'd0, 8'd7, 3'd3, 2'b01}));
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Cold start with immediate arready and back-to-back beats.
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0000;
        @(negedge clk);
        t_redir = cyc_cnt;
        tick();
        redirect_valid = 1'b0;
        t_ar = -1; t_last = -1; t_val = -1;
        for (int i = 0; i < 100 && t_val < 0; i++) begin
            @(negedge clk);
            if (m_axi_arvalid && t_ar < 0) t_ar = cyc_cnt;
            if (m_axi_rvalid && m_axi_rready && m_axi_rlast && t_last < 0) t_last = cyc_cnt;
            if (instr_valid) t_val = cyc_cnt;
            else tick();
        end
        check_eq("t1_ar_latency", 64'(t_ar - t_redir), 64'd2);
        check_eq("t1_valid_latency", 64'(t_val - t_last), 64'd1);
        check_eq("t1_first_pc", instr_pc, 64'h8000_0000);
        check_eq("t1_first_instr", 64'(instr), 64'(instr_at(64'h8000_0000)));
        nvalid = 0;
        for (int i = 0; i < 16; i++) begin
            if (instr_valid) nvalid++;
            tick();
            @(negedge clk);
        end
        check_eq("t1_burst16", 64'(nvalid), 64'd16);

        // Line crossing after 0x...3C.
        check_eq("t2_miss_valid", 64'(instr_valid), 64'd0);
        tick();
        wait_ar(64'h8000_0040, 10, "t2_ar");
        tick();
        wait_valid_pc(64'h8000_0040, 50, "t2_resume");

        // Redirect that hits in the resident line.
        tick();
        instr_ready = 1'b0;
        do_redirect(64'h8000_0000);
        wait_valid_pc(64'h8000_0000, 50, "t4_refill_line0");
        tick();
        instr_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0030;
        @(negedge clk);
        check_eq("t4_pre_pc", instr_pc, 64'h8000_0008);
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        check_eq("t4_hit_valid", 64'(instr_valid), 64'd1);
        check_eq("t4_hit_pc", instr_pc, 64'h8000_0030);
        check_eq("t4_no_ar", 64'(m_axi_arvalid), 64'd0);

        // Backpressure at 0x...10.
        tick();
        do_redirect(64'h8000_0012);
        @(negedge clk);
        held_instr = instr;
        check_eq("t3_pc", instr_pc, 64'h8000_0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check_eq("t3_stall_valid", 64'(instr_valid), 64'd1);
            check_eq("t3_stall_pc", instr_pc, 64'h8000_0010);
            check_eq("t3_stall_instr", 64'(instr), 64'(held_instr));
        end
        tick();
        instr_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_accept_pc", instr_pc, 64'h8000_0010);
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        check_eq("t3_advance_pc", instr_pc, 64'h8000_0014);

        // Redirect while the AR is stalled.
        tick();
        ar_delay_knob = 4;
        instr_ready = 1'b1;
        wait_ar(64'h8000_0040, 40, "t5_ar");
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h9000_0000;
        @(negedge clk);
        check_eq("t5_hold_redir", m_axi_araddr, 64'h8000_0040);
        tick();
        redirect_valid = 1'b0;
        n_low = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_axi_arvalid) check_eq("t5_hold", m_axi_araddr, 64'h8000_0040);
            if (m_axi_arvalid && m_axi_arready) break;
            if (m_axi_arvalid) n_low++;
            tick();
        end
        check_eq("t5_stall_len", 64'(n_low), 64'd2);
        tick();
        ar_delay_knob = 0;
        wait_ar(64'h9000_0000, 60, "t5_second_ar");
        tick();
        wait_valid_pc(64'h9000_0000, 60, "t5_first_valid");

        // PC wrap at the top of the address space.
        tick();
        do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
        wait_valid_pc(64'h0, 80, "wrap_zero");

        // Asynchronous reset in the middle of a fill.
        tick();
        do_redirect(64'hA000_0000);
        nb = 0;
        for (int i = 0; i < 60 && nb < 3; i++) begin
            @(negedge clk);
            if (m_axi_rvalid && m_axi_rready) nb++;
            tick();
        end
        check_eq("t6_pre_rready", 64'(m_axi_rready), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async", 64'({m_axi_arvalid, m_axi_rready, instr_valid}), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t6_idle", 64'({instr_valid, m_axi_arvalid, m_axi_rready}), 64'd0);
            tick();
        end
        do_redirect(64'h8000_0000);
        wait_ar(64'h8000_0000, 10, "t6_fresh_ar");
        tick();
        wait_valid_pc(64'h8000_0000, 40, "t6_valid");

        // Randomized traffic: ready, redirects, AR and R throttling.
        tick();
        r_rand = 1'b1;
        ar_delay_knob = -1;
        acc0 = n_acc;
        for (int i = 0; i < 3000; i++) begin
            redirect_valid = ($urandom_range(0, 23) == 0);
            if (redirect_valid) redirect_pc = pick_pc();
            instr_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        check_eq("rand_progress", 64'((n_acc - acc0) > 50), 64'd1);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
